xdisp_scan: RTL and testbench

Memory-mapped scan controller for the 4-digit multiplexed 7-segment display on the controller data bus. It holds four digit registers and one control register, written by the controller through the address decoder. It time-multiplexes the anodes with a programmable on-time and an anode-off dead time between digits, decodes hex to segments, and optionally suppresses leading zeros. It drives the top-level `disp_ctrl` pins.

---
 rtl/xdisp_scan_pkg.sv | 21 ++
 rtl/xdisp_scan_seg7_dec.sv | 33 +++
 rtl/xdisp_scan.sv | 164 ++++++++++++++++
 tb/tb_xdisp_scan.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/xdisp_scan_pkg.sv
// Shared definitions for the 4-digit 7-segment scan controller:
// register offsets, register bit positions and scan FSM encodings.
package xdisp_scan_pkg;

   localparam logic [2:0] OFS_CTRL = 3'd4;
   localparam logic [2:0] OFS_STAT = 3'd5;

   localparam int DIG_DP    = 4;
   localparam int DIG_BLANK = 5;
   localparam int CTRL_EN   = 0;
   localparam int CTRL_LZS  = 1;

   localparam logic [11:0] DISP_DARK = 12'hFFF;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_ON   = 2'd1,
      ST_DEAD = 2'd2
   } scan_state_t;

endpackage

// File: rtl/xdisp_scan_seg7_dec.sv
// Hex digit to active-low 7-segment pattern (bit order g..a), with blanking.
module xseg7_dec (
   input  logic [3:0] value,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h7F;
      if (!blank) begin
         case (value)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
         endcase
      end
   end

endmodule

// File: rtl/xdisp_scan.sv
// Memory-mapped multiplexed 4-digit display scanner: digit/control registers,
// ON/DEAD anode timing, hex decode and leading-zero suppression.
module xdisp_scan
   import xdisp_scan_pkg::*;
#(
   parameter int PRESCALE    = 50000,
   parameter int DEAD_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic        we,
   input  logic [2:0]  addr,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic [11:0] disp_ctrl
);

   localparam int CNT_MAX = (PRESCALE > DEAD_CYCLES) ? PRESCALE : DEAD_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

   logic [5:0]       digit_reg [4];
   logic [5:0]       digit_eff [4];
   logic [1:0]       ctrl_reg;
   scan_state_t      state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [1:0]       idx_reg, idx_next;
   logic [5:0]       shadow_digit_reg;
   logic             shadow_sup_reg;
   logic             load_shadow;
   logic [11:0]      disp_reg, disp_next;
   logic [6:0]       seg_dec;

   logic             wr, digit_wr, ctrl_wr, en_wr, dis_wr, lzs_eff;
   logic [3:1]       digit_zero;
   logic [3:0]       sup;
   logic             unused_bits;

   assign wr       = sel & we;
   assign digit_wr = wr & ~addr[2];
   assign ctrl_wr  = wr & (addr == OFS_CTRL);
   assign en_wr    = ctrl_wr & data_in[CTRL_EN];
   assign dis_wr   = ctrl_wr & ~data_in[CTRL_EN];
   assign lzs_eff  = ctrl_wr ? data_in[CTRL_LZS] : ctrl_reg[CTRL_LZS];
   assign unused_bits = ^data_in[7:6];

   // Write-forwarded digit values so a write on the ON-entry edge reaches the shadow.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_eff
         assign digit_eff[gi] = (digit_wr && addr[1:0] == 2'(gi)) ? data_in[5:0] : digit_reg[gi];
      end
      for (gi = 1; gi < 4; gi++) begin : g_sup
         assign digit_zero[gi] = (digit_eff[gi][3:0] == 4'h0);
         assign sup[gi]        = lzs_eff & (&digit_zero[3:gi]);
      end
   endgenerate
   assign sup[0] = 1'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) digit_reg[i] <= '0;
         ctrl_reg <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (digit_wr && addr[1:0] == 2'(i)) digit_reg[i] <= data_in[5:0];
         end
         if (ctrl_wr) ctrl_reg <= data_in[1:0];
      end
   end

   xseg7_dec u_dec (
      .value (shadow_digit_reg[3:0]),
      .blank (shadow_digit_reg[DIG_BLANK] | shadow_sup_reg),
      .seg   (seg_dec)
   );

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      idx_next    = idx_reg;
      load_shadow = 1'b0;
      case (state_reg)
         ST_OFF: begin
            if (en_wr) begin
               state_next  = ST_ON;
               cnt_next    = '0;
               idx_next    = '0;
               load_shadow = 1'b1;
            end
         end
         ST_ON: begin
            if (cnt_reg == ON_LAST) begin
               state_next = ST_DEAD;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_DEAD: begin
            if (cnt_reg == DEAD_LAST) begin
               state_next  = ST_ON;
               cnt_next    = '0;
               idx_next    = idx_reg + 2'd1;
               load_shadow = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = ST_OFF;
            cnt_next   = '0;
            idx_next   = '0;
         end
      endcase
      if (dis_wr) begin
         state_next  = ST_OFF;
         cnt_next    = '0;
         idx_next    = '0;
         load_shadow = 1'b0;
      end
      // Blank on the same edge that captures a disable so the outputs go dark in one cycle.
      disp_next = DISP_DARK;
      if (state_reg == ST_ON && !dis_wr)
         disp_next = {~(4'b0001 << idx_reg), ~shadow_digit_reg[DIG_DP], seg_dec};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg        <= ST_OFF;
         cnt_reg          <= '0;
         idx_reg          <= '0;
         shadow_digit_reg <= '0;
         shadow_sup_reg   <= 1'b0;
         disp_reg         <= DISP_DARK;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         disp_reg  <= disp_next;
         if (load_shadow) begin
            shadow_digit_reg <= digit_eff[idx_next];
            shadow_sup_reg   <= sup[idx_next];
         end
      end
   end

   assign disp_ctrl = disp_reg;

   always_comb begin
      data_out = 8'h00;
      if (sel) begin
         if (!addr[2])
            data_out = {2'b00, digit_reg[addr[1:0]]};
         else if (addr == OFS_CTRL)
            data_out = {6'b0, ctrl_reg};
         else if (addr == OFS_STAT)
            data_out = {5'b0, state_reg == ST_DEAD, idx_reg};
      end
   end

endmodule

// File: tb/tb_xdisp_scan.sv
// Vector-table bench for xdisp_scan (PRESCALE=4, DEAD_CYCLES=2): one vector per
// clock, plus a hand-written asynchronous reset sequence at the end.
module tb_xdisp_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel, we;
   logic [2:0]  addr;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic [11:0] disp_ctrl;

   xdisp_scan #(.PRESCALE(4), .DEAD_CYCLES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .sel       (sel),
      .we        (we),
      .addr      (addr),
      .data_in   (data_in),
      .data_out  (data_out),
      .disp_ctrl (disp_ctrl)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sel;
      logic        we;
      logic [2:0]  addr;
      logic [7:0]  din;
      logic [11:0] disp;
      logic [7:0]  dout;
   } vec_t;

   vec_t vq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic void add(input logic s, input logic w, input logic [2:0] a,
                               input logic [7:0] d, input logic [11:0] dp, input logic [7:0] o);
      vec_t v;
      v.sel = s; v.we = w; v.addr = a; v.din = d; v.disp = dp; v.dout = o;
      vq.push_back(v);
   endfunction

   // Cycle j after the enabling write: STAT reflects scan step j-1, disp_ctrl step j-2.
   // Each digit occupies 6 steps: 4 ON then 2 DEAD.
   function automatic void gen_range(input logic [11:0] p0, input logic [11:0] p1,
                                     input logic [11:0] p2, input logic [11:0] p3,
                                     input int j0, input int j1);
      logic [11:0] pats [4];
      logic [11:0] dsp;
      logic [7:0]  st;
      int          t, tp;
      pats[0] = p0; pats[1] = p1; pats[2] = p2; pats[3] = p3;
      for (int j = j0; j <= j1; j++) begin
         t  = j - 1;
         tp = j - 2;
         st = 8'((t / 6) % 4);
         if ((t % 6) >= 4) st[2] = 1'b1;
         dsp = 12'hFFF;
         if (j > 1 && (tp % 6) < 4) dsp = pats[(tp / 6) % 4];
         add(1'b1, 1'b0, 3'd5, 8'h00, dsp, st);
      end
   endfunction

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      int b;
      rst = 1'b0; sel = 1'b0; we = 1'b0; addr = 3'd0; data_in = 8'h00;

      // Reset: every register and the display read dark/zero.
      for (int a = 0; a < 8; a++) add(1'b1, 1'b0, 3'(a), 8'h00, 12'hFFF, 8'h00);
      // Basic scan: digits 1,2,3,4, readback, sel gating, then enable.
      for (int d = 0; d < 4; d++) add(1'b1, 1'b1, 3'(d), 8'(d + 1), 12'hFFF, 8'h00);
      for (int d = 0; d < 4; d++) add(1'b1, 1'b0, 3'(d), 8'h00, 12'hFFF, 8'(d + 1));
      add(1'b0, 1'b0, 3'd2, 8'h00, 12'hFFF, 8'h00);
      add(1'b1, 1'b1, 3'd4, 8'h01, 12'hFFF, 8'h00);
      gen_range(12'hEF9, 12'hDA4, 12'hBB0, 12'h799, 1, 40);
      // Disable during DEAD of digit 2.
      add(1'b1, 1'b1, 3'd4, 8'h00, 12'hBB0, 8'h00);
      add(1'b1, 1'b0, 3'd5, 8'h00, 12'hFFF, 8'h00);
      add(1'b1, 1'b0, 3'd4, 8'h00, 12'hFFF, 8'h00);
      // Re-enable: mid-phase DIGIT0 write, DIGIT1 write on the ON-entry edge,
      // and a CTRL rewrite that keeps EN set.
      add(1'b1, 1'b1, 3'd4, 8'h01, 12'hFFF, 8'h00);
      b = vq.size();
      gen_range(12'hEF9, 12'hD88, 12'hBB0, 12'h799, 1, 25);
      gen_range(12'hE80, 12'hD88, 12'hBB0, 12'h799, 26, 31);
      vq[b + 1].we  = 1'b1; vq[b + 1].addr  = 3'd0; vq[b + 1].din  = 8'h08;
      vq[b + 5].we  = 1'b1; vq[b + 5].addr  = 3'd1; vq[b + 5].din  = 8'h0A;
      vq[b + 13].we = 1'b1; vq[b + 13].addr = 3'd4; vq[b + 13].din = 8'h01;
      add(1'b1, 1'b1, 3'd4, 8'h00, 12'hD88, 8'h00);
      add(1'b1, 1'b0, 3'd5, 8'h00, 12'hFFF, 8'h00);
      // Leading-zero suppression with dp on the blanked digit 3.
      add(1'b1, 1'b1, 3'd3, 8'h10, 12'hFFF, 8'h00);
      add(1'b1, 1'b1, 3'd2, 8'h00, 12'hFFF, 8'h00);
      add(1'b1, 1'b1, 3'd1, 8'h05, 12'hFFF, 8'h00);
      add(1'b1, 1'b1, 3'd0, 8'h00, 12'hFFF, 8'h00);
      add(1'b1, 1'b1, 3'd4, 8'h03, 12'hFFF, 8'h00);
      gen_range(12'hEC0, 12'hD92, 12'hBFF, 12'h77F, 1, 25);

      repeat (3) @(negedge clk);
      chk("reset_disp", disp_ctrl, 12'hFFF);
      rst = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         chk($sformatf("v%0d disp", i), disp_ctrl, vq[i].disp);
         sel = vq[i].sel; we = vq[i].we; addr = vq[i].addr; data_in = vq[i].din;
         #1;
         if (!vq[i].we) chk($sformatf("v%0d dout", i), {4'h0, data_out}, {4'h0, vq[i].dout});
         $display("vec %0d sel=%b we=%b addr=%0d din=%h disp=%h dout=%h",
                  i, vq[i].sel, vq[i].we, vq[i].addr, vq[i].din, disp_ctrl, data_out);
      end

      // Asynchronous reset in the middle of digit 0's ON phase.
      @(negedge clk);
      chk("pre_rst disp", disp_ctrl, 12'hEC0);
      sel = 1'b1; we = 1'b0; addr = 3'd1;
      #1;
      chk("pre_rst dig1", {4'h0, data_out}, 12'h005);
      #2;
      rst = 1'b0;
      #1;
      chk("async disp", disp_ctrl, 12'hFFF);
      chk("async dig1", {4'h0, data_out}, 12'h000);
      addr = 3'd5;
      #1;
      chk("async stat", {4'h0, data_out}, 12'h000);
      addr = 3'd4;
      #1;
      chk("async ctrl", {4'h0, data_out}, 12'h000);
      $display("async reset sequence disp=%h", disp_ctrl);
      @(negedge clk);
      rst = 1'b1; sel = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("post_rst disp%0d", k), disp_ctrl, 12'hFFF);
         chk($sformatf("post_rst dout%0d", k), {4'h0, data_out}, 12'h000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
